seg7_capture: RTL and testbench
===============================

Name: seg7_capture

Overview:
- Receive-side counterpart of the team's 3-bit to 7-segment encoder.
- Watches a multiplexed, active-low 7-segment bus (segment lines plus digit-select lines) and recovers the 0–7 value shown on each digit.
- Filters glitches by requiring the bus to be stable for STABLE_CYC clocks before capturing.
- Used in the lab boards' self-check harness and as a loop-back monitor next to the display driver.

Parameters:
- NDIG, 4: number of multiplexed digits (An width); range 1–8.
- STABLE_CYC, 4: consecutive identical samples required before capture; range 2–255.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- Seg  input  7  segment lines, active-low; bit0=a … bit6=g.
- An  input  NDIG  digit selects, active-low; exactly one low means a valid strobe.
- D  output  3*NDIG  captured values; digit k in D[3k+2:3k].
- Valid  output  NDIG  per-digit flag: D slice holds a legally decoded value.
- Err  output  NDIG  per-digit sticky flag: an illegal pattern was captured.
- Upd  output  1  one-cycle pulse on every capture.
- UpdIdx  output  3  digit index of the latest capture; meaningful while Upd=1.

Behaviour:
- Reset values: D=0, Valid=0, Err=0, Upd=0, UpdIdx=0. Internal sample S = {Seg=7'h7F, An=all ones}, counter C=0, state IDLE.
- Decode works on the active-high pattern P=~Seg:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7.
  - P=00 is blank.
  - Any other P is illegal.
- Sampling and counting, each edge, with X={Seg,An}:
  - X≠S: S←X, C←1.
  - X==S and C<STABLE_CYC: C←C+1.
  - X==S and C==STABLE_CYC: C holds (saturates).
- States:
  - IDLE: An has zero or ≥2 bits low. No capture. Enter TRACK when exactly one An bit is low.
  - TRACK: counting toward STABLE_CYC. On the edge where C goes STABLE_CYC-1→STABLE_CYC, perform a capture and go to HELD.
  - HELD: pattern already captured; no further captures. Go to TRACK if X changes while still a single strobe, or to IDLE if An is no longer a single strobe.
- Capture action on the capture edge, with k = index of the low An bit:
  - Legal P: D[k]←value, Valid[k]←1.
  - Blank: D[k] unchanged, Valid[k]←0.
  - Illegal: D[k] unchanged, Valid[k]←0, Err[k]←1.
  - In all three cases: Upd←1 and UpdIdx←k for exactly the next cycle.
- Latency: if X is new and constant before edges 1..N (N=STABLE_CYC), the capture happens at edge N, and Upd is high between edges N and N+1.
- Boundary conditions:
  - Any change of X, including a single-bit glitch, restarts the count at 1. A glitch shorter than STABLE_CYC never captures.
  - A pattern change within the same digit causes recapture after STABLE_CYC further stable edges.
  - Err bits clear only on RST.
  - Digits not being strobed keep their D, Valid and Err.
  - RST mid-count discards the partial count. RST has priority over capture on the same edge.
  - UpdIdx is 3 bits wide regardless of NDIG.

Optional Feature:
- Macro: SEG7CAP_ERRCNT_EN.
- Defined:
  - Adds output port ErrCnt [7:0].
  - ErrCnt increments on every illegal-pattern capture, any digit, saturates at 255, and resets to 0 on RST.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- RST high 2 cycles, then idle bus (Seg=7F, An=F) -> D=0, Valid=0, Err=0, Upd never asserted.
- Seg=~7'h5B, An=4'b1101 held 4 edges (STABLE_CYC=4) -> at edge 4: D[5:3]=2, Valid=4'b0010, Upd=1 for one cycle, UpdIdx=1. Holding 10 more edges -> no further Upd.
- Seg=~7'h07 on An=1110 held 3 edges, then a 1-cycle glitch Seg=~7'h06, then ~7'h07 again -> no capture until 4 stable edges after the glitch; then D[2:0]=7.
- Scan all 4 digits with 0,3,6,1, each held 5 edges -> D=12'b001_110_011_000, Valid=F, four Upd pulses with UpdIdx 0..3.
- Seg=~7'h49 (illegal) on An=0111 held 4 edges -> Err=1000, Valid[3]=0, Upd=1, D[11:9] unchanged. With SEG7CAP_ERRCNT_EN, ErrCnt=1.
- An=1100 (two strobes) held 10 edges -> no Upd. Then RST asserted during a 2-edge partial count on a legal pattern -> all outputs return to reset values and no capture occurs.

Source files
------------

// File: rtl/seg7_capture.sv
// seg7_capture: receive-side monitor for a multiplexed, active-low 7-segment bus.
// It recovers the 0-7 value shown on each digit once the bus has held the same
// {Seg,An} sample for STABLE_CYC clocks.
// Optional: define SEG7CAP_ERRCNT_EN to add the saturating ErrCnt[7:0] output.
//
// Handshake: there is no back-pressure. Upd is a one-cycle valid pulse with no
// ready. UpdIdx and the matching D/Valid/Err slice are stable while Upd=1.
module seg7_capture #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [6:0]          Seg,
  input  logic [NDIG-1:0]     An,
  output logic [3*NDIG-1:0]   D,
  output logic [NDIG-1:0]     Valid,
  output logic [NDIG-1:0]     Err,
  output logic                Upd,
  output logic [2:0]          UpdIdx
`ifdef SEG7CAP_ERRCNT_EN
  ,
  output logic [7:0]          ErrCnt
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC);
  localparam logic [7:0] CNT_PRE = 8'(STABLE_CYC - 1);

  logic [1:0]        state_q, state_d;
  logic [6:0]        seg_s_q, seg_s_d;
  logic [NDIG-1:0]   an_s_q, an_s_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3*NDIG-1:0] d_q, d_d;
  logic [NDIG-1:0]   valid_q, valid_d;
  logic [NDIG-1:0]   err_q, err_d;
  logic              upd_q, upd_d;
  logic [2:0]        upd_idx_q, upd_idx_d;
`ifdef SEG7CAP_ERRCNT_EN
  logic [7:0]        err_cnt_q, err_cnt_d;
`endif

  logic       x_same;
  logic       single;
  logic [3:0] n_low;
  logic [2:0] low_idx;
  logic       capture;
  logic [6:0] pat;
  logic       pat_legal;
  logic       pat_blank;
  logic [2:0] pat_val;

  // Strobe analysis and decode of the active-high segment pattern.
  always_comb begin
    x_same  = (Seg == seg_s_q) && (An == an_s_q);
    n_low   = 4'd0;
    low_idx = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (!An[i]) begin
        n_low   = n_low + 4'd1;
        low_idx = 3'(i);
      end
    end
    single    = (n_low == 4'd1);
    pat       = ~Seg;
    pat_legal = 1'b1;
    pat_blank = 1'b0;
    pat_val   = 3'd0;
    case (pat)
      7'h3F: pat_val = 3'd0;
      7'h06: pat_val = 3'd1;
      7'h5B: pat_val = 3'd2;
      7'h4F: pat_val = 3'd3;
      7'h66: pat_val = 3'd4;
      7'h6D: pat_val = 3'd5;
      7'h7D: pat_val = 3'd6;
      7'h07: pat_val = 3'd7;
      7'h00: begin pat_legal = 1'b0; pat_blank = 1'b1; end
      default: pat_legal = 1'b0;
    endcase
  end

  // Stability counter, FSM next state and capture update.
  always_comb begin
    seg_s_d   = Seg;
    an_s_d    = An;
    state_d   = state_q;
    d_d       = d_q;
    valid_d   = valid_q;
    err_d     = err_q;
    upd_d     = 1'b0;
    upd_idx_d = upd_idx_q;
    capture   = 1'b0;
`ifdef SEG7CAP_ERRCNT_EN
    err_cnt_d = err_cnt_q;
`endif

    if (!x_same)                cnt_d = 8'd1;
    else if (cnt_q < CNT_MAX)   cnt_d = cnt_q + 8'd1;
    else                        cnt_d = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (single) state_d = ST_TRACK;
      end
      ST_TRACK: begin
        if (!single) state_d = ST_IDLE;
        else if (x_same && cnt_q == CNT_PRE) begin
          capture = 1'b1;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!single)     state_d = ST_IDLE;
        else if (!x_same) state_d = ST_TRACK;
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      upd_d     = 1'b1;
      upd_idx_d = low_idx;
      for (int i = 0; i < NDIG; i++) begin
        if (low_idx == 3'(i)) begin
          valid_d[i] = pat_legal;
          if (pat_legal) d_d[3*i +: 3] = pat_val;
          if (!pat_legal && !pat_blank) err_d[i] = 1'b1;
        end
      end
`ifdef SEG7CAP_ERRCNT_EN
      if (!pat_legal && !pat_blank && err_cnt_q != 8'hFF)
        err_cnt_d = err_cnt_q + 8'd1;
`endif
    end
  end

  // State registers; reset wins over a capture on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      seg_s_q   <= 7'h7F;
      an_s_q    <= '1;
      cnt_q     <= 8'd0;
      d_q       <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= 3'd0;
`ifdef SEG7CAP_ERRCNT_EN
      err_cnt_q <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      seg_s_q   <= seg_s_d;
      an_s_q    <= an_s_d;
      cnt_q     <= cnt_d;
      d_q       <= d_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
`ifdef SEG7CAP_ERRCNT_EN
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign D      = d_q;
  assign Valid  = valid_q;
  assign Err    = err_q;
  assign Upd    = upd_q;
  assign UpdIdx = upd_idx_q;
`ifdef SEG7CAP_ERRCNT_EN
  assign ErrCnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scenarios followed by random bus traffic,
// checked every cycle against a run-length reference model.
module tb_seg7_capture;

  localparam int NDIG = 4;
  localparam int SC   = 4;

  logic              CLK;
  logic              RST;
  logic [6:0]        Seg;
  logic [NDIG-1:0]   An;
  logic [3*NDIG-1:0] D;
  logic [NDIG-1:0]   Valid;
  logic [NDIG-1:0]   Err;
  logic              Upd;
  logic [2:0]        UpdIdx;
`ifdef SEG7CAP_ERRCNT_EN
  logic [7:0]        ErrCnt;
`endif

  seg7_capture #(.NDIG(NDIG), .STABLE_CYC(SC)) dut (
    .CLK(CLK), .RST(RST), .Seg(Seg), .An(An),
    .D(D), .Valid(Valid), .Err(Err), .Upd(Upd), .UpdIdx(UpdIdx)
`ifdef SEG7CAP_ERRCNT_EN
    , .ErrCnt(ErrCnt)
`endif
  );

  // Clock and reset defaults
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: length of the current run of identical samples.
  logic [6:0] seg_tbl [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
  logic [10:0] m_last;
  int          m_run;
  logic [2:0]  m_d   [NDIG];
  logic        m_v   [NDIG];
  logic        m_e   [NDIG];
  int          m_errcnt;
  logic        m_upd;
  logic [2:0]  exp_q [$];

  task automatic model_reset();
    m_last   = {7'h7F, 4'hF};
    m_run    = 0;
    m_upd    = 1'b0;
    m_errcnt = 0;
    for (int i = 0; i < NDIG; i++) begin
      m_d[i] = 3'd0; m_v[i] = 1'b0; m_e[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [6:0] seg, input logic [NDIG-1:0] an, input logic rst);
    int nlow, k, val;
    logic [6:0] p;
    if (rst) begin
      model_reset();
      return;
    end
    if ({seg, an} == m_last) m_run++;
    else m_run = 1;
    m_last = {seg, an};
    m_upd  = 1'b0;
    nlow = 0; k = 0;
    for (int i = 0; i < NDIG; i++) if (!an[i]) begin nlow++; k = i; end
    if (nlow == 1 && m_run == SC) begin
      p = ~seg;
      val = -1;
      for (int v = 0; v < 8; v++) if (seg_tbl[v] == p) val = v;
      if (val >= 0) begin
        m_d[k] = 3'(val); m_v[k] = 1'b1;
      end else if (p == 7'h00) begin
        m_v[k] = 1'b0;
      end else begin
        m_v[k] = 1'b0; m_e[k] = 1'b1;
        if (m_errcnt < 255) m_errcnt++;
      end
      m_upd = 1'b1;
      exp_q.push_back(3'(k));
    end
  endtask

  // Driver: apply inputs for one edge, advance the model, compare after the edge
  task automatic cycle(input logic [6:0] seg, input logic [NDIG-1:0] an, input logic rst);
    logic [3*NDIG-1:0] ed;
    logic [NDIG-1:0]   ev, ee;
    logic [2:0]        idx;
    Seg = seg; An = an; RST = rst;
    model_edge(seg, an, rst);
    @(posedge CLK);
    #1;
    for (int i = 0; i < NDIG; i++) begin
      ed[3*i +: 3] = m_d[i]; ev[i] = m_v[i]; ee[i] = m_e[i];
    end
    check_val("D", 32'(D), 32'(ed));
    check_val("Valid", 32'(Valid), 32'(ev));
    check_val("Err", 32'(Err), 32'(ee));
    check_val("Upd", 32'(Upd), 32'(m_upd));
`ifdef SEG7CAP_ERRCNT_EN
    check_val("ErrCnt", 32'(ErrCnt), 32'(m_errcnt));
`endif
    if (Upd === 1'b1) begin
      if (exp_q.size() == 0) check_val("upd_unexpected", 32'(1), 32'(0));
      else begin
        idx = exp_q.pop_front();
        check_val("UpdIdx", 32'(UpdIdx), 32'(idx));
      end
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic hold(input logic [6:0] seg, input logic [NDIG-1:0] an, input int n);
    for (int i = 0; i < n; i++) cycle(seg, an, 1'b0);
  endtask

  int upd_seen;

  initial begin
    logic [6:0] pat, gseg;
    logic [NDIG-1:0] an;
    int k, len, gpos, sel;
    RST = 1'b1; Seg = 7'h7F; An = 4'hF;
    model_reset();
    @(posedge CLK); #1;

    // Reset and idle bus
    cycle(7'h7F, 4'hF, 1'b1);
    cycle(7'h7F, 4'hF, 1'b1);
    check_val("reset_D", 32'(D), 32'd0);
    check_val("reset_UpdIdx", 32'(UpdIdx), 32'd0);
    hold(7'h7F, 4'hF, 6);

    // Digit 1 shows 2; exactly one Upd over 14 edges
    upd_seen = 0;
    for (int i = 0; i < 14; i++) begin
      cycle(~7'h5B, 4'b1101, 1'b0);
      if (Upd === 1'b1) upd_seen++;
      if (i == 3) check_val("plan_upd_edge4", 32'(Upd), 32'd1);
    end
    check_val("plan_upd_count", 32'(upd_seen), 32'd1);
    check_val("plan_d1", 32'(D[5:3]), 32'd2);

    // Glitch restarts the count
    hold(~7'h07, 4'b1110, 3);
    hold(~7'h06, 4'b1110, 1);
    hold(~7'h07, 4'b1110, 3);
    check_val("plan_glitch_noupd", 32'(Upd), 32'd0);
    hold(~7'h07, 4'b1110, 1);
    check_val("plan_glitch_upd", 32'(Upd), 32'd1);
    check_val("plan_d0", 32'(D[2:0]), 32'd7);

    // Scan four digits with 0,3,6,1
    hold(~seg_tbl[0], 4'b1110, 5);
    hold(~seg_tbl[3], 4'b1101, 5);
    hold(~seg_tbl[6], 4'b1011, 5);
    hold(~seg_tbl[1], 4'b0111, 5);
    check_val("plan_scan_D", 32'(D), 32'b001_110_011_000);
    check_val("plan_scan_V", 32'(Valid), 32'hF);

    // Illegal pattern on digit 3
    hold(~7'h49, 4'b0111, 4);
    check_val("plan_illegal_upd", 32'(Upd), 32'd1);
    check_val("plan_illegal_err", 32'(Err), 32'b1000);
    check_val("plan_illegal_d3", 32'(D[11:9]), 32'd1);

    // Two strobes never capture, then reset discards a partial count
    hold(~7'h3F, 4'b1100, 10);
    hold(~7'h66, 4'b1011, 2);
    cycle(~7'h66, 4'b1011, 1'b1);
    check_val("plan_rst_err", 32'(Err), 32'd0);
    hold(~7'h66, 4'b1011, 2);
    hold(7'h7F, 4'hF, 3);

    // Random traffic
    for (int it = 0; it < 150; it++) begin
      k = $urandom_range(0, NDIG - 1);
      sel = $urandom_range(0, 99);
      if (sel < 70)      pat = seg_tbl[$urandom_range(0, 7)];
      else if (sel < 85) pat = 7'h00;
      else               pat = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 99) < 85) an = ~(4'b0001 << k);
      else an = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 8);
      gpos = ($urandom_range(0, 99) < 20) ? $urandom_range(0, len - 1) : -1;
      for (int c = 0; c < len; c++) begin
        gseg = ~pat;
        if (c == gpos) gseg[$urandom_range(0, 6)] ^= 1'b1;
        cycle(gseg, an, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
